inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised next-generation instruction fetcher.
- Fetches from the I-cache (single-cycle hit) or from the memory controller (miss path), and predicts next PC for JAL and conditional branches.
- Pushes {PC, inst, pred} into an internal FIFO so decode stalls no longer freeze fetch.
- Sits between I-cache / memory controller / predictor and the decoder; flushed by the ROB.

Parameters:
- ADDR_WIDTH, 32, PC and address width.
- INST_WIDTH, 32, instruction width (opcode in bits [6:0]).
- QDEPTH_LOG, 3, queue holds 2**QDEPTH_LOG entries.
- RESET_PC, 0, PC after reset.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- clr_in  in  1  flush (mispredict).
- clr_pc  in  ADDR_WIDTH  redirect target, valid with clr_in.
- ic_fetch_addr  out  ADDR_WIDTH  equals PC (combinational).
- ic_hit  in  1  I-cache hit for ic_fetch_addr, same cycle.
- ic_hit_inst  in  INST_WIDTH  hit data.
- ic_wr_valid  out  1  one-cycle I-cache fill pulse.
- ic_wr_addr  out  ADDR_WIDTH  fill address.
- ic_wr_inst  out  INST_WIDTH  fill data.
- mc_req  out  1  memory read request, held until mc_ack.
- mc_addr  out  ADDR_WIDTH  request address.
- mc_ack  in  1  request accepted.
- mc_valid  in  1  read data return.
- mc_inst  in  INST_WIDTH  returned instruction.
- pr_pc  out  ADDR_WIDTH  equals PC (combinational).
- pr_taken  in  1  predictor direction for pr_pc.
- dc_valid  out  1  queue non-empty.
- dc_pc  out  ADDR_WIDTH  head PC.
- dc_inst  out  INST_WIDTH  head instruction.
- dc_pred  out  1  head predicted-taken.
- dc_pop  in  1  decoder consumes head.
- q_count  out  QDEPTH_LOG+1  occupancy.

Behaviour:
- Reset (async):
  - PC=RESET_PC; state=IDLE; pointers and count 0.
  - mc_req=0, mc_addr=0, ic_wr_valid=0, ic_wr_addr=0, ic_wr_inst=0, dc_valid=0.
- rdy_in=0: no state, pointer or output-register change. mc_valid and mc_ack are ignored.
- Head outputs: combinational from entry at the read pointer. dc_valid = (count != 0).
- Next-PC / prediction, applied to the fetched inst I at PC:
  - opcode 1101111 (JAL): nxt = PC + sext({I[31],I[19:12],I[20],I[30:21],0}), pred=1.
  - opcode 1100011 (branch): pred=pr_taken; nxt = pred ? PC + sext({I[31],I[7],I[30:25],I[11:8],0}) : PC+4.
  - Otherwise: nxt=PC+4, pred=0.
  - All sums wrap mod 2**ADDR_WIDTH.
- States: IDLE, MISS_REQ, MISS_WAIT, DISCARD.
- IDLE, count < depth:
  - ic_hit=1: push {PC, ic_hit_inst, pred}; PC<=nxt; stay in IDLE. Zero-bubble, one instruction per cycle.
  - ic_hit=0: mc_req<=1, mc_addr<=PC, go to MISS_REQ.
  - Queue full: no fetch; stay in IDLE.
- MISS_REQ: hold mc_req and mc_addr. On mc_ack: mc_req<=0, go to MISS_WAIT.
- MISS_WAIT: on mc_valid, in the same edge:
  - push {PC, mc_inst, pred};
  - ic_wr_valid<=1, ic_wr_addr<=mc_addr, ic_wr_inst<=mc_inst;
  - PC<=nxt, go to IDLE.
  - A miss is issued only when count < depth, so this push never overflows.
- DISCARD: wait for the stale response. On mc_valid: still perform the I-cache fill (data is correct for mc_addr); no push, no PC change; go to IDLE.
- ic_wr_valid is a one-cycle pulse; it is cleared on every other active edge.
- Push and pop in the same cycle: count unchanged. dc_pop while empty is ignored. Pointers wrap mod depth.
- clr_in=1 (rdy_in high) has priority over fetch, push and pop:
  - pointers and count <= 0; PC<=clr_pc.
  - IDLE: stay in IDLE.
  - MISS_REQ without mc_ack: mc_req<=0, go to IDLE.
  - MISS_REQ with mc_ack: mc_req<=0, go to DISCARD.
  - MISS_WAIT without mc_valid: go to DISCARD.
  - MISS_WAIT with mc_valid: fill the I-cache, drop the push, go to IDLE.
  - DISCARD: stay in DISCARD; a same-cycle mc_valid moves it to IDLE.
  - A fetch resumes from clr_pc on the next IDLE cycle.
- Reset mid-miss: returns to IDLE immediately. The memory controller is also reset, so no stale response arrives.

Test Plan:
- Reset, RESET_PC=0, ic_hit=1 with NOPs (0x00000013) every cycle, dc_pop=0 -> pushes at PC 0,4,...,0x1C; q_count reaches 8; ic_fetch_addr holds 0x20; no further pushes.
- ic_hit=0 at PC 0x100, mc_ack after 2 cycles, mc_valid with 0x0080006F (JAL +8) after 3 more -> one push {0x100, 0x0080006F, 1}; ic_wr pulse addr 0x100; PC=0x108.
- Branch 0xFE000EE3 (beq, offset -4) at 0x200 via hit, pr_taken=1 -> dc_pred=1, next PC 0x1FC; same with pr_taken=0 -> PC 0x204, dc_pred=0.
- Queue at 3 entries, simultaneous hit push and dc_pop -> q_count stays 3; head advances in order.
- In MISS_WAIT, clr_in=1 with clr_pc=0x400 -> queue empty, state DISCARD. A later mc_valid gives an ic_wr pulse and no push. The next fetch is at 0x400.
- rdy_in=0 for 5 cycles with ic_hit=1 and dc_pop=1 -> PC, q_count and the head entry are unchanged.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetcher with I-cache/miss path, next-PC prediction and decode queue
// Fetch runs ahead of decode into a small FIFO; a flush redirects PC and drops queued entries.
module inst_fetch_queue #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           INST_WIDTH = 32,
   parameter int unsigned           QDEPTH_LOG = 3,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clr_in,
   input  logic [ADDR_WIDTH-1:0] clr_pc,
   output logic [ADDR_WIDTH-1:0] ic_fetch_addr,
   input  logic                  ic_hit,
   input  logic [INST_WIDTH-1:0] ic_hit_inst,
   output logic                  ic_wr_valid,
   output logic [ADDR_WIDTH-1:0] ic_wr_addr,
   output logic [INST_WIDTH-1:0] ic_wr_inst,
   output logic                  mc_req,
   output logic [ADDR_WIDTH-1:0] mc_addr,
   input  logic                  mc_ack,
   input  logic                  mc_valid,
   input  logic [INST_WIDTH-1:0] mc_inst,
   output logic [ADDR_WIDTH-1:0] pr_pc,
   input  logic                  pr_taken,
   output logic                  dc_valid,
   output logic [ADDR_WIDTH-1:0] dc_pc,
   output logic [INST_WIDTH-1:0] dc_inst,
   output logic                  dc_pred,
   input  logic                  dc_pop,
   output logic [QDEPTH_LOG:0]   q_count
);

   localparam int unsigned DEPTH = 1 << QDEPTH_LOG;
   localparam logic [QDEPTH_LOG:0] DEPTH_C = {1'b1, {QDEPTH_LOG{1'b0}}};

   typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, DISCARD} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   pc;
   logic [QDEPTH_LOG-1:0]   wr_ptr, rd_ptr;
   logic [QDEPTH_LOG:0]     count;

   logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
   logic [INST_WIDTH-1:0]   inst_mem [DEPTH];
   logic                    pred_mem [DEPTH];

   logic                    push, pop, fill, req_set, req_clr;
   logic [INST_WIDTH-1:0]   fetch_inst;
   logic [ADDR_WIDTH-1:0]   nxt_pc;
   logic                    pred;
   logic [20:0]             j_imm;
   logic [12:0]             b_imm;

   assign ic_fetch_addr = pc;
   assign pr_pc         = pc;
   assign q_count       = count;
   assign dc_valid      = (count != '0);
   assign dc_pc         = pc_mem[rd_ptr];
   assign dc_inst       = inst_mem[rd_ptr];
   assign dc_pred       = pred_mem[rd_ptr];

   // Only a MISS_WAIT push uses memory data; every other push comes from the cache.
   assign fetch_inst = (state == MISS_WAIT) ? mc_inst : ic_hit_inst;
   assign j_imm = {fetch_inst[31], fetch_inst[19:12], fetch_inst[20], fetch_inst[30:21], 1'b0};
   assign b_imm = {fetch_inst[31], fetch_inst[7], fetch_inst[30:25], fetch_inst[11:8], 1'b0};

   always_comb begin
      nxt_pc = pc + ADDR_WIDTH'(4);
      pred   = 1'b0;
      if (fetch_inst[6:0] == 7'b1101111) begin
         pred   = 1'b1;
         nxt_pc = pc + {{(ADDR_WIDTH-21){j_imm[20]}}, j_imm};
      end else if (fetch_inst[6:0] == 7'b1100011) begin
         pred = pr_taken;
         if (pr_taken) nxt_pc = pc + {{(ADDR_WIDTH-13){b_imm[12]}}, b_imm};
      end
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      fill      = 1'b0;
      req_set   = 1'b0;
      req_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (!clr_in && count < DEPTH_C) begin
               if (ic_hit) begin
                  push = 1'b1;
               end else begin
                  req_set   = 1'b1;
                  state_nxt = MISS_REQ;
               end
            end
         end
         MISS_REQ: begin
            if (mc_ack) begin
               req_clr   = 1'b1;
               state_nxt = clr_in ? DISCARD : MISS_WAIT;
            end else if (clr_in) begin
               req_clr   = 1'b1;
               state_nxt = IDLE;
            end
         end
         MISS_WAIT: begin
            if (mc_valid) begin
               fill      = 1'b1;
               push      = !clr_in;
               state_nxt = IDLE;
            end else if (clr_in) begin
               state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            // The stale line is still valid for mc_addr, so the cache keeps it.
            if (mc_valid) begin
               fill      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      pop = dc_pop && (count != '0) && !clr_in;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         mc_req      <= 1'b0;
         mc_addr     <= '0;
         ic_wr_valid <= 1'b0;
         ic_wr_addr  <= '0;
         ic_wr_inst  <= '0;
      end else if (rdy_in) begin
         state       <= state_nxt;
         ic_wr_valid <= fill;
         if (fill) begin
            ic_wr_addr <= mc_addr;
            ic_wr_inst <= mc_inst;
         end
         if (req_set) begin
            mc_req  <= 1'b1;
            mc_addr <= pc;
         end else if (req_clr) begin
            mc_req <= 1'b0;
         end
         if (clr_in) begin
            pc     <= clr_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               pc     <= nxt_pc;
               wr_ptr <= wr_ptr + QDEPTH_LOG'(1);
            end
            if (pop) rd_ptr <= rd_ptr + QDEPTH_LOG'(1);
            if (push && !pop)      count <= count + (QDEPTH_LOG+1)'(1);
            else if (pop && !push) count <= count - (QDEPTH_LOG+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in && push) begin
         pc_mem[wr_ptr]   <= pc;
         inst_mem[wr_ptr] <= fetch_inst;
         pred_mem[wr_ptr] <= pred;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clr_in, ic_hit, mc_ack, mc_valid, pr_taken, dc_pop;
   logic [31:0] clr_pc, ic_hit_inst, mc_inst;
   logic [31:0] ic_fetch_addr, ic_wr_addr, ic_wr_inst, mc_addr, pr_pc, dc_pc, dc_inst;
   logic        ic_wr_valid, mc_req, dc_valid, dc_pred;
   logic [3:0]  q_count;

   int checks = 0;
   int failures = 0;

   inst_fetch_queue dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in), .clr_pc(clr_pc),
      .ic_fetch_addr(ic_fetch_addr), .ic_hit(ic_hit), .ic_hit_inst(ic_hit_inst),
      .ic_wr_valid(ic_wr_valid), .ic_wr_addr(ic_wr_addr), .ic_wr_inst(ic_wr_inst),
      .mc_req(mc_req), .mc_addr(mc_addr), .mc_ack(mc_ack), .mc_valid(mc_valid), .mc_inst(mc_inst),
      .pr_pc(pr_pc), .pr_taken(pr_taken), .dc_valid(dc_valid), .dc_pc(dc_pc), .dc_inst(dc_inst),
      .dc_pred(dc_pred), .dc_pop(dc_pop), .q_count(q_count)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc, m_addr, m_wr_a, m_wr_i;
   logic        m_req, m_wait, m_stale, m_wr_v;

   localparam logic [31:0] NOP = 32'h0000_0013;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offsets rebuilt from their bit fields as signed integer sums.
   function automatic void predict(input logic [31:0] pc, input logic [31:0] inst, input logic taken,
                                   output logic [31:0] nxt, output logic pr);
      int off;
      off = 4;
      pr  = 1'b0;
      if (inst[6:0] == 7'b1101111) begin
         pr  = 1'b1;
         off = (inst[31] ? -1048576 : 0) + (int'(inst[19:12]) << 12) + (int'(inst[20]) << 11)
               + (int'(inst[30:21]) << 1);
      end else if (inst[6:0] == 7'b1100011 && taken) begin
         pr  = 1'b1;
         off = (inst[31] ? -4096 : 0) + (int'(inst[7]) << 11) + (int'(inst[30:25]) << 5)
               + (int'(inst[11:8]) << 1);
      end
      nxt = pc + off;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pc = 32'h0; m_addr = 32'h0; m_wr_a = 32'h0; m_wr_i = 32'h0;
      m_req = 1'b0; m_wait = 1'b0; m_stale = 1'b0; m_wr_v = 1'b0;
   endtask

   task automatic model_step();
      logic [31:0] nxt;
      logic        pr;
      int          had;
      if (!rdy_in) return;
      had    = mq.size();
      m_wr_v = 1'b0;
      if ((m_wait || m_stale) && mc_valid) begin
         m_wr_v = 1'b1; m_wr_a = m_addr; m_wr_i = mc_inst;
         if (m_wait && !clr_in) begin
            predict(m_pc, mc_inst, pr_taken, nxt, pr);
            mq.push_back('{m_pc, mc_inst, pr});
            m_pc = nxt;
         end
         m_wait = 1'b0; m_stale = 1'b0;
      end else if (m_wait) begin
         if (clr_in) begin m_wait = 1'b0; m_stale = 1'b1; end
      end else if (m_stale) begin
      end else if (m_req) begin
         if (mc_ack) begin
            m_req = 1'b0;
            if (clr_in) m_stale = 1'b1; else m_wait = 1'b1;
         end else if (clr_in) m_req = 1'b0;
      end else if (!clr_in && had < 8) begin
         if (ic_hit) begin
            predict(m_pc, ic_hit_inst, pr_taken, nxt, pr);
            mq.push_back('{m_pc, ic_hit_inst, pr});
            m_pc = nxt;
         end else begin
            m_req = 1'b1; m_addr = m_pc;
         end
      end
      if (clr_in) begin
         mq.delete();
         m_pc = clr_pc;
      end else if (dc_pop && had > 0) begin
         void'(mq.pop_front());
      end
   endtask

   task automatic check_all();
      chk("fetch_addr", ic_fetch_addr, m_pc);
      chk("pr_pc", pr_pc, m_pc);
      chk("q_count", q_count, mq.size());
      chk("dc_valid", dc_valid, mq.size() != 0);
      if (mq.size() > 0) begin
         chk("dc_pc", dc_pc, mq[0].pc);
         chk("dc_inst", dc_inst, mq[0].inst);
         chk("dc_pred", dc_pred, mq[0].pred);
      end
      chk("mc_req", mc_req, m_req);
      chk("mc_addr", mc_addr, m_addr);
      chk("ic_wr_valid", ic_wr_valid, m_wr_v);
      chk("ic_wr_addr", ic_wr_addr, m_wr_a);
      chk("ic_wr_inst", ic_wr_inst, m_wr_i);
   endtask

   task automatic cycle();
      @(negedge clk_in);
      check_all();
      model_step();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; clr_pc = 32'h0;
      ic_hit = 1'b0; ic_hit_inst = NOP; mc_ack = 1'b0; mc_valid = 1'b0; mc_inst = 32'h0;
      pr_taken = 1'b0; dc_pop = 1'b0;
      model_reset();
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      chk("reset_fetch", ic_fetch_addr, 32'h0);
      chk("reset_count", q_count, 4'd0);
      chk("reset_req", mc_req, 1'b0);
      chk("reset_wr", ic_wr_valid, 1'b0);
      chk("reset_dcv", dc_valid, 1'b0);

      // fill the queue with hits until it is full
      ic_hit = 1'b1;
      repeat (10) cycle();
      chk("full_count", q_count, 4'd8);
      chk("full_pc", ic_fetch_addr, 32'h20);
      chk("full_head", dc_pc, 32'h0);

      // miss path returning a JAL +8
      clr_in = 1'b1; clr_pc = 32'h100; ic_hit = 1'b0;
      cycle();
      clr_in = 1'b0;
      cycle(); cycle();
      mc_ack = 1'b1; cycle(); mc_ack = 1'b0;
      repeat (3) cycle();
      mc_valid = 1'b1; mc_inst = 32'h0080006F; cycle(); mc_valid = 1'b0;
      chk("miss_count", q_count, 4'd1);
      chk("miss_pc", dc_pc, 32'h100);
      chk("miss_inst", dc_inst, 32'h0080006F);
      chk("miss_pred", dc_pred, 1'b1);
      chk("miss_wrv", ic_wr_valid, 1'b1);
      chk("miss_wra", ic_wr_addr, 32'h100);
      chk("miss_nxt", ic_fetch_addr, 32'h108);

      // backward branch, taken then not taken
      clr_in = 1'b1; clr_pc = 32'h200; cycle();
      clr_in = 1'b0; ic_hit = 1'b1; ic_hit_inst = 32'hFE000EE3; pr_taken = 1'b1; cycle();
      chk("br_t_pred", dc_pred, 1'b1);
      chk("br_t_pc", ic_fetch_addr, 32'h1FC);
      clr_in = 1'b1; clr_pc = 32'h200; cycle();
      clr_in = 1'b0; pr_taken = 1'b0; cycle();
      chk("br_n_pred", dc_pred, 1'b0);
      chk("br_n_pc", ic_fetch_addr, 32'h204);

      // simultaneous push and pop at three entries
      clr_in = 1'b1; clr_pc = 32'h300; cycle();
      clr_in = 1'b0; ic_hit_inst = NOP; repeat (3) cycle();
      chk("q3_count", q_count, 4'd3);
      dc_pop = 1'b1; repeat (4) cycle(); dc_pop = 1'b0;
      chk("q3_hold", q_count, 4'd3);
      chk("q3_head", dc_pc, 32'h310);

      // flush while waiting for miss data
      clr_in = 1'b1; clr_pc = 32'h380; ic_hit = 1'b0; cycle();
      clr_in = 1'b0; cycle();
      mc_ack = 1'b1; cycle(); mc_ack = 1'b0;
      cycle();
      clr_in = 1'b1; clr_pc = 32'h400; cycle(); clr_in = 1'b0;
      chk("disc_count", q_count, 4'd0);
      repeat (2) cycle();
      mc_valid = 1'b1; mc_inst = 32'hDEAD_BEEF; cycle(); mc_valid = 1'b0;
      chk("disc_wrv", ic_wr_valid, 1'b1);
      chk("disc_wra", ic_wr_addr, 32'h380);
      chk("disc_nopush", q_count, 4'd0);
      chk("disc_pc", ic_fetch_addr, 32'h400);
      ic_hit = 1'b1; cycle();
      chk("redir_head", dc_pc, 32'h400);

      // global stall
      rdy_in = 1'b0; dc_pop = 1'b1; mc_valid = 1'b1;
      repeat (5) cycle();
      chk("stall_pc", ic_fetch_addr, 32'h404);
      chk("stall_count", q_count, 4'd1);
      chk("stall_head", dc_pc, 32'h400);
      rdy_in = 1'b1; dc_pop = 1'b0; mc_valid = 1'b0;

      // asynchronous reset in the middle of a miss
      ic_hit = 1'b0; cycle();
      chk("pre_rst_req", mc_req, 1'b1);
      #2 rst_in = 1'b1;
      model_reset();
      #1;
      chk("arst_req", mc_req, 1'b0);
      chk("arst_pc", ic_fetch_addr, 32'h0);
      chk("arst_count", q_count, 4'd0);
      @(posedge clk_in); #1 rst_in = 1'b0;

      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r;
         r = $urandom;
         case ($urandom_range(0, 3))
            0: r[6:0] = 7'b1101111;
            1: r[6:0] = 7'b1100011;
            default: ;
         endcase
         ic_hit_inst = r;
         r = $urandom;
         if ($urandom_range(0, 1) == 1) r[6:0] = 7'b1100011;
         mc_inst  = r;
         ic_hit   = ($urandom_range(0, 9) < 7);
         pr_taken = $urandom_range(0, 1) == 1;
         dc_pop   = ($urandom_range(0, 9) < 4);
         mc_ack   = ($urandom_range(0, 9) < 4);
         mc_valid = ($urandom_range(0, 9) < 3);
         clr_in   = ($urandom_range(0, 99) < 3);
         clr_pc   = $urandom & 32'hFFFF_FFFC;
         rdy_in   = ($urandom_range(0, 9) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
